// File: rtl/exp_arg_scaler_pkg.sv
// rtl/exp_arg_scaler_pkg.sv - shared q32.32 types and constants for the exponent-argument path
package exp_arg_scaler_pkg;

    localparam int DATA_W = 64;
    localparam int FRAC_W = 32;

    typedef logic signed [63:0] q32_32_t;

    localparam q32_32_t Q_ONE     = 64'sh0000_0001_0000_0000;
    localparam q32_32_t Q_NEG_ONE = 64'shFFFF_FFFF_0000_0000;
    localparam q32_32_t Q_MAX     = 64'sh7FFF_FFFF_FFFF_FFFF;
    localparam q32_32_t Q_MIN     = 64'sh8000_0000_0000_0000;
    // Symmetric negative limit, so that negating a saturated value never wraps
    localparam q32_32_t Q_NEG_MAX = 64'sh8000_0000_0000_0001;

endpackage

// File: rtl/q_sat_clamp.sv
// rtl/q_sat_clamp.sv - combinational q64.64 -> q32.32 slice, saturate, optional negate, clamp to [-1,+1]
//   i_prod    : signed q64.64 product
//   o_arg     : signed q32.32 result within [-1.0, +1.0]
//   o_clamped : result was saturated or clamped
module q_sat_clamp
    import exp_arg_scaler_pkg::*;
#(
    parameter int DATA_W = 64,
    parameter int FRAC_W = 32,
    parameter bit NEGATE = 1'b1
) (
    input  logic signed [2*DATA_W-1:0] i_prod,
    output logic signed [DATA_W-1:0]   o_arg,
    output logic                       o_clamped
);

    // Bits above the kept slice plus its sign bit; they must all agree for the slice to be exact
    localparam int TOP_W = DATA_W - FRAC_W + 1;

    logic [TOP_W-1:0]          w_top;
    logic                      w_ovf;
    logic                      w_hi;
    logic                      w_lo;
    logic signed [DATA_W-1:0]  w_r;
    logic signed [DATA_W-1:0]  w_v;
    logic                      w_unused_frac;

    assign w_top         = i_prod[2*DATA_W-1 -: TOP_W];
    assign w_ovf         = !((&w_top) || !(|w_top));
    // Low fraction bits are dropped by design: truncation toward minus infinity
    assign w_unused_frac = ^i_prod[FRAC_W-1:0];

    always_comb begin
        w_r = i_prod[DATA_W+FRAC_W-1:FRAC_W];
        if (w_ovf) begin
            w_r = i_prod[2*DATA_W-1] ? Q_NEG_MAX : Q_MAX;
        end
        w_v = w_r;
        if (NEGATE) begin
            // An exact in-range Q_MIN slice would wrap on negation; map it to +MAX
            w_v = (w_r == Q_MIN) ? Q_MAX : -w_r;
        end
        w_hi      = (w_v > Q_ONE);
        w_lo      = (w_v < Q_NEG_ONE);
        o_arg     = w_hi ? Q_ONE : (w_lo ? Q_NEG_ONE : w_v);
        o_clamped = w_ovf | w_hi | w_lo;
    end

endmodule

// File: rtl/exp_arg_scaler.sv
// rtl/exp_arg_scaler.sv - forms clamped exponent argument -kappa*delta through a 2-stage valid/ready pipeline
//   i_clk, i_rst_n         : clock, asynchronous active-low reset
//   i_valid/o_ready        : operand handshake for i_kappa, i_delta (signed q32.32)
//   o_valid/i_ready        : result handshake for o_arg (q32.32 in [-1,+1]) and o_clamped
//   o_clamp_cnt            : saturating count of clamped transfers, only with EXP_ARG_STATS_EN defined
module exp_arg_scaler
    import exp_arg_scaler_pkg::*;
#(
    parameter int DATA_W = 64,
    parameter int FRAC_W = 32,
    parameter bit NEGATE = 1'b1
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_valid,
    output logic              o_ready,
    input  logic [DATA_W-1:0] i_kappa,
    input  logic [DATA_W-1:0] i_delta,
    output logic              o_valid,
    input  logic              i_ready,
    output logic [DATA_W-1:0] o_arg,
    output logic              o_clamped
`ifdef EXP_ARG_STATS_EN
    ,
    output logic [31:0]       o_clamp_cnt
`endif
);

    logic                       w_adv1;
    logic                       w_adv2;
    logic signed [2*DATA_W-1:0] w_kappa_x;
    logic signed [2*DATA_W-1:0] w_delta_x;
    logic signed [2*DATA_W-1:0] w_prod;
    logic signed [DATA_W-1:0]   w_arg;
    logic                       w_clamped;

    logic                       r_s1_valid;
    logic signed [2*DATA_W-1:0] r_prod;
    logic                       r_s2_valid;
    logic [DATA_W-1:0]          r_arg;
    logic                       r_clamped;

    // Each stage advances when it is empty or the stage after it is moving
    assign w_adv2  = !r_s2_valid || i_ready;
    assign w_adv1  = !r_s1_valid || w_adv2;
    assign o_ready = w_adv1;

    assign w_kappa_x = {{DATA_W{i_kappa[DATA_W-1]}}, i_kappa};
    assign w_delta_x = {{DATA_W{i_delta[DATA_W-1]}}, i_delta};
    assign w_prod    = w_kappa_x * w_delta_x;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_s1_valid <= 1'b0;
            r_prod     <= '0;
        end else if (w_adv1) begin
            r_s1_valid <= i_valid;
            if (i_valid) begin
                r_prod <= w_prod;
            end
        end
    end

    q_sat_clamp #(
        .DATA_W (DATA_W),
        .FRAC_W (FRAC_W),
        .NEGATE (NEGATE)
    ) u_sat_clamp (
        .i_prod    (r_prod),
        .o_arg     (w_arg),
        .o_clamped (w_clamped)
    );

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_s2_valid <= 1'b0;
            r_arg      <= '0;
            r_clamped  <= 1'b0;
        end else if (w_adv2) begin
            r_s2_valid <= r_s1_valid;
            if (r_s1_valid) begin
                r_arg     <= w_arg;
                r_clamped <= w_clamped;
            end
        end
    end

    assign o_valid   = r_s2_valid;
    assign o_arg     = r_arg;
    assign o_clamped = r_clamped;

`ifdef EXP_ARG_STATS_EN
    logic [31:0] r_clamp_cnt;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_clamp_cnt <= '0;
        end else if (r_s2_valid && i_ready && r_clamped && (r_clamp_cnt != 32'hFFFF_FFFF)) begin
            r_clamp_cnt <= r_clamp_cnt + 32'd1;
        end
    end

    assign o_clamp_cnt = r_clamp_cnt;
`endif

endmodule

// File: tb/tb_exp_arg_scaler.sv
// tb/tb_exp_arg_scaler.sv - scoreboard bench for exp_arg_scaler against an arithmetic reference model
module tb_exp_arg_scaler;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        i_valid;
    logic        o_ready;
    logic [63:0] i_kappa;
    logic [63:0] i_delta;
    logic        o_valid;
    logic        i_ready;
    logic [63:0] o_arg;
    logic        o_clamped;
`ifdef EXP_ARG_STATS_EN
    logic [31:0] o_clamp_cnt;
    int          model_cnt = 0;
`endif

    always #5 clk = ~clk;

    exp_arg_scaler dut (
        .i_clk     (clk),
        .i_rst_n   (rst_n),
        .i_valid   (i_valid),
        .o_ready   (o_ready),
        .i_kappa   (i_kappa),
        .i_delta   (i_delta),
        .o_valid   (o_valid),
        .i_ready   (i_ready),
        .o_arg     (o_arg),
        .o_clamped (o_clamped)
`ifdef EXP_ARG_STATS_EN
        ,
        .o_clamp_cnt (o_clamp_cnt)
`endif
    );

    int          errors = 0;
    int          checks = 0;
    int          n_acc  = 0;
    logic [63:0] exp_arg_q[$];
    logic        exp_clp_q[$];
    bit          ov_en = 0;
    logic [63:0] ov_arg;
    logic        ov_clp;
    bit          hold_pending = 0;
    logic [63:0] hold_arg;
    logic        hold_clp;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    // Reference: exact product, floor to q32.32, negate, clamp to [-1,+1] in unbounded arithmetic
    function automatic void model(input logic [63:0] k, input logic [63:0] d,
                                  output logic [63:0] a, output logic c);
        logic signed [129:0] ks, ds, p, x, v, one;
        ks  = $signed(k);
        ds  = $signed(d);
        one = 130'sd4294967296;
        p   = ks * ds;
        x   = p >>> 32;
        v   = -x;
        if (v > one) begin
            a = 64'h0000_0001_0000_0000; c = 1'b1;
        end else if (v < -one) begin
            a = 64'hFFFF_FFFF_0000_0000; c = 1'b1;
        end else begin
            a = v[63:0]; c = 1'b0;
        end
    endfunction

    function automatic logic [63:0] rnd_q();
        logic [63:0] r;
        r = {$urandom, $urandom};
        case ($urandom_range(0, 2))
            0:       return r;
            1:       return {{30{r[33]}}, r[33:0]};
            default: return {{32{r[31]}}, r[31:0]};
        endcase
    endfunction

    // Accept side of the scoreboard
    always @(negedge clk) begin
        logic [63:0] a;
        logic        c;
        if (rst_n && i_valid && o_ready) begin
            n_acc++;
            if (ov_en) begin
                a = ov_arg; c = ov_clp;
            end else begin
                model(i_kappa, i_delta, a, c);
            end
            exp_arg_q.push_back(a);
            exp_clp_q.push_back(c);
        end
    end

    // Output monitor
    always @(negedge clk) begin
        if (!rst_n) begin
            hold_pending = 0;
        end else begin
            if (hold_pending) begin
                check("hold_valid", {63'd0, o_valid}, 64'd1);
                check("hold_arg", o_arg, hold_arg);
                check("hold_clamped", {63'd0, o_clamped}, {63'd0, hold_clp});
            end
            hold_pending = 0;
            if (o_valid) begin
                if (i_ready) begin
                    if (exp_arg_q.size() == 0) begin
                        checks++; errors++;
                        $display("FAIL unexpected_output actual=%h required=none", o_arg);
                    end else begin
                        logic [63:0] ea;
                        logic        ec;
                        ea = exp_arg_q.pop_front();
                        ec = exp_clp_q.pop_front();
                        check("arg", o_arg, ea);
                        check("clamped", {63'd0, o_clamped}, {63'd0, ec});
`ifdef EXP_ARG_STATS_EN
                        if (ec && model_cnt != 32'hFFFF_FFFF) model_cnt++;
`endif
                    end
                end else begin
                    hold_pending = 1;
                    hold_arg     = o_arg;
                    hold_clp     = o_clamped;
                end
            end
        end
    end

    task automatic send(input logic [63:0] k, input logic [63:0] d);
        bit ok;
        ok      = 0;
        i_valid = 1'b1;
        i_kappa = k;
        i_delta = d;
        for (int n = 0; n < 100; n++) begin
            @(negedge clk);
            if (o_ready) begin
                ok = 1;
                break;
            end
        end
        if (!ok) begin
            checks++; errors++;
            $display("FAIL accept_timeout actual=o_ready_low required=accept");
        end
        @(posedge clk);
        #1;
        i_valid = 1'b0;
        ov_en   = 0;
    endtask

    task automatic send_dir(input logic [63:0] k, input logic [63:0] d,
                            input logic [63:0] a, input logic c);
        ov_en  = 1;
        ov_arg = a;
        ov_clp = c;
        send(k, d);
    endtask

    task automatic drain();
        for (int n = 0; n < 50 && exp_arg_q.size() != 0; n++) @(posedge clk);
        #1;
        check("drain_empty", 64'(exp_arg_q.size()), 64'd0);
    endtask

    initial begin
        int base;
        rst_n   = 1'b0;
        i_valid = 1'b0;
        i_ready = 1'b1;
        i_kappa = '0;
        i_delta = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_o_valid", {63'd0, o_valid}, 64'd0);
        check("reset_o_arg", o_arg, 64'd0);
        check("reset_o_clamped", {63'd0, o_clamped}, 64'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("idle_o_ready", {63'd0, o_ready}, 64'd1);

        send_dir(64'h0000_0001_8000_0000, 64'h0000_0000_8000_0000, 64'hFFFF_FFFF_4000_0000, 1'b0);
        send_dir(64'h0000_0002_0000_0000, 64'hFFFF_FFFF_C000_0000, 64'h0000_0000_8000_0000, 1'b0);
        send_dir(64'h0000_0002_0000_0000, 64'h0000_0001_0000_0000, 64'hFFFF_FFFF_0000_0000, 1'b1);
        send_dir(64'h7FFF_FFFF_0000_0000, 64'h7FFF_FFFF_0000_0000, 64'hFFFF_FFFF_0000_0000, 1'b1);
        send_dir(64'h0000_0001_0000_0000, 64'h0000_0001_0000_0000, 64'hFFFF_FFFF_0000_0000, 1'b0);
        send_dir(64'hFFFF_FFFF_0000_0000, 64'h0000_0001_0000_0000, 64'h0000_0001_0000_0000, 1'b0);
        send_dir(64'h8000_0000_0000_0000, 64'h0000_0001_0000_0000, 64'h0000_0001_0000_0000, 1'b1);
        send_dir(64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_0000_0000, 1'b1);
        drain();

        // Back-pressure: 4 back-to-back pairs against a stalled consumer
        i_ready = 1'b0;
        base    = n_acc;
        fork
            for (int j = 0; j < 4; j++) send(rnd_q(), rnd_q());
        join_none
        repeat (5) @(posedge clk);
        #1;
        check("bp_accepts", 64'(n_acc - base), 64'd2);
        check("bp_o_ready", {63'd0, o_ready}, 64'd0);
        i_ready = 1'b1;
        wait fork;
        drain();
        check("bp_total", 64'(n_acc - base), 64'd4);

        // Reset with two items in flight
        i_ready = 1'b0;
        send(rnd_q(), rnd_q());
        send(rnd_q(), rnd_q());
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_o_valid", {63'd0, o_valid}, 64'd0);
        check("rst_o_arg", o_arg, 64'd0);
        check("rst_o_clamped", {63'd0, o_clamped}, 64'd0);
        exp_arg_q.delete();
        exp_clp_q.delete();
`ifdef EXP_ARG_STATS_EN
        model_cnt = 0;
`endif
        repeat (2) @(posedge clk);
        #2;
        rst_n   = 1'b1;
        i_ready = 1'b1;
        @(posedge clk);
        #1;
        send_dir(64'h0000_0000_4000_0000, 64'h0000_0000_4000_0000, 64'hFFFF_FFFF_F000_0000, 1'b0);
        drain();

        // Randomized traffic with random downstream stalls
        fork
            begin
                repeat (400) begin
                    @(posedge clk);
                    #1;
                    i_ready = ($urandom_range(0, 3) != 0);
                end
                i_ready = 1'b1;
            end
        join_none
        for (int j = 0; j < 250; j++) begin
            if ($urandom_range(0, 4) == 0) begin
                @(posedge clk);
                #1;
            end
            send(rnd_q(), rnd_q());
        end
        wait fork;
        i_ready = 1'b1;
        drain();

`ifdef EXP_ARG_STATS_EN
        check("clamp_cnt", {32'd0, o_clamp_cnt}, 64'(model_cnt));
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/exp_arg_scaler.md
Name: exp_arg_scaler

Overview:
Upstream stage of the exponential look-up. Takes the intensity decay coefficient kappa and a quote spread delta, both q32.32, and forms the exponent argument -kappa*delta. It saturates and clamps the result to the look-up domain [-1.0, +1.0], then presents it through a 2-stage valid/ready pipeline. Its output drives the exponential LUT's signed q32.32 input directly.

Parameters:
DATA_W, 64, total fixed-point width (q32.32)
FRAC_W, 32, fractional bits
NEGATE, 1, 1: output = -(kappa*delta); 0: output = kappa*delta

Ports:
i_clk  input  1  clock
i_rst_n  input  1  asynchronous active-low reset
i_valid  input  1  input operands valid
o_ready  output  1  stage can accept operands this cycle
i_kappa  input  64  signed q32.32 coefficient
i_delta  input  64  signed q32.32 spread
o_valid  output  1  o_arg valid
i_ready  input  1  downstream accepts o_arg
o_arg  output  64  signed q32.32 clamped argument, range [-1.0, +1.0]
o_clamped  output  1  o_arg was clamped or saturated (qualified by o_valid)

Behaviour:
- Reset is asynchronous on the falling edge of i_rst_n. While reset is asserted: s1_valid=0, s2_valid=0, o_valid=0, o_arg=0, o_clamped=0. All in-flight data is discarded; nothing is emitted after reset.
- Handshake: a transfer happens on a rising edge with valid&ready.
  - o_valid stays high and o_arg/o_clamped stay stable until i_ready is sampled high.
- Pipeline (full throughput, latency 2 cycles from input accept to o_valid):
  - S1: register the 128-bit signed product i_kappa*i_delta (q64.64).
  - S2: slice, saturate, negate, clamp; register o_arg/o_clamped.
- Stall logic:
  - adv2 = !s2_valid | i_ready
  - adv1 = !s1_valid | adv2
  - o_ready = adv1 (combinational)
  - Simultaneous accept and emit in the same cycle is legal; throughput is 1 per cycle when i_ready=1.
- Arithmetic in S2:
  - r = prod[95:32].
  - If prod[127:95] is not all-equal (overflow), r = +MAX when prod[127]=0, else r = -MAX; set ovf.
  - If NEGATE, v = -r. The most-negative value is pre-saturated so negation cannot wrap.
  - Clamp: if v > 0x0000_0001_0000_0000 then o_arg = 0x0000_0001_0000_0000. If v < 0xFFFF_FFFF_0000_0000 then o_arg = 0xFFFF_FFFF_0000_0000. Otherwise o_arg = v.
  - o_clamped = ovf | clamp active. Exactly +1.0 or -1.0 passes through unclamped (o_clamped=0).
- Truncation: truncate toward minus infinity (plain bit slice, no rounding).
- Input change while o_ready=0 is ignored; operands are sampled only on accept.

Optional Feature:
EXP_ARG_STATS_EN
- Defined: adds output o_clamp_cnt [31:0]. It increments once per output transfer (o_valid&i_ready) with o_clamped=1, saturates at 0xFFFF_FFFF, and resets to 0.
- Undefined: port and counter absent; behaviour otherwise identical.

Decomposition:
- Shared package: Q_ONE (0x0000_0001_0000_0000), Q_NEG_ONE (0xFFFF_FFFF_0000_0000), q32_32_t typedef (logic signed [63:0]), and FRAC_W constant, shared with the exponential LUT.
- One sub-module is natural: q_sat_clamp, the combinational S2 slice/saturate/negate/clamp. The top level holds the pipeline registers and handshake.

Test Plan:
- kappa=0x0000_0001_8000_0000 (1.5), delta=0x0000_0000_8000_0000 (0.5), i_ready=1 -> 2 cycles later o_arg=0xFFFF_FFFF_4000_0000 (-0.75), o_clamped=0.
- kappa=0x0000_0002_0000_0000 (2.0), delta=0xFFFF_FFFF_C000_0000 (-0.25) -> o_arg=0x0000_0000_8000_0000 (+0.5); kappa=2.0, delta=1.0 -> o_arg=0xFFFF_FFFF_0000_0000, o_clamped=1.
- kappa=delta=0x7FFF_FFFF_0000_0000 (overflow) -> o_arg=0xFFFF_FFFF_0000_0000, o_clamped=1; kappa=1.0, delta=1.0 -> o_arg=Q_NEG_ONE, o_clamped=0.
- Back-pressure: stream 4 operand pairs back to back, hold i_ready=0 for 5 cycles -> o_ready drops after 2 accepts, o_arg held stable; on release all 4 results appear in order with no loss or duplication.
- Pull i_rst_n low mid-stream with 2 items in flight -> o_valid=0 immediately; after release the first o_valid corresponds to the first post-reset accept.
- With EXP_ARG_STATS_EN: 3 clamped and 2 unclamped transfers -> o_clamp_cnt=3; one clamped result held under i_ready=0 for 4 cycles counts once.
